switch_alloc_np: RTL and testbench
==================================

Name: switch_alloc_np

Overview:
Parametrised wormhole switch allocator for the NoC router. Generalises the fixed 4-port allocator to NUM_PORTS ports, with a PORT_MASK for absent ports such as edge routers. Each output has a built-in round-robin arbiter and a per-output packet lock. Sits between the input FIFOs (route labels computed upstream) and the output links; output data and valid are registered.

Parameters:
NUM_PORTS, 5, number of router ports; port 0 = Local, 1..N-1 = link directions.
DATASIZE, 40, flit width; bits [1:0] = flit type.
PORT_MASK, 5'b11111, bit i = 0 marks port i absent: its input is ignored and its output is never driven valid.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_label  input  NUM_PORTS*NUM_PORTS  one-hot request of input i in slice [i*N +: N]; bit j = wants output j; all-zero = no request
in_data  input  NUM_PORTS*DATASIZE  head flit of each input FIFO, slice [i*DATASIZE +: DATASIZE]
out_full  input  NUM_PORTS  downstream of output j cannot accept a flit
in_ready  output  NUM_PORTS  input i granted this cycle; FIFO pops its flit
out_valid  output  NUM_PORTS  registered, flit present on output j
out_data  output  NUM_PORTS*DATASIZE  registered flit per output

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0.
  - All RR pointers=0; all locks IDLE.
  - in_ready forced 0 while rst_n=0.
- Flit type [1:0]: 01 head, 00 body, 10 tail, 11 single.
- Request cleaning:
  - Self-request bit (input i -> output i) is ignored, except for i=0.
  - Multi-hot label: only the lowest set bit is honoured.
  - Masked inputs and outputs are ignored.
- Output j is eligible when out_full[j]=0 and PORT_MASK[j]=1.
- Per-output lock FSM:
  - IDLE: RR arbitration among requesters of j whose flit is head or single. Scan starts at ptr[j] and wraps modulo NUM_PORTS (non-power-of-2 wraps correctly). First requester k wins.
  - Head granted -> LOCKED(owner=k). Single granted -> stay IDLE, ptr[j] = (k+1) mod N.
  - LOCKED(k): only input k can be granted, for any flit type. Tail granted -> IDLE, ptr[j] = (k+1) mod N.
  - Body or tail flits requesting an IDLE output are never granted (protocol error; no state change).
- Grant is combinational in the same cycle: in_ready[i]=1 iff input i is granted by its requested output.
- Output register, 1-cycle latency:
  - On grant, out_data[j] <= granted flit and out_valid[j] <= 1.
  - Otherwise out_valid[j] <= 0; out_data holds its last value.
- Backpressure: out_full[j]=1 -> no grant on j; lock and pointer hold; in_ready of the waiting input stays 0.
- An output never grants more than one input per cycle. Each input requests at most one output, so no input-side conflict exists.
- Reset mid-packet clears all locks; remaining flits are the upstream's problem.
- Combinational path in_label/out_full -> in_ready must contain no latch.

Optional Feature:
Macro SA_STATS_EN.
- Defined: adds input stat_clr (1 bit) and output stat_grant_cnt (NUM_PORTS*16).
  - Counter for output j is 16 bits, saturating at 16'hFFFF.
  - It increments on every grant on output j.
  - Synchronous clear on stat_clr; clear has priority over increment.
  - Async reset to 0.
- Undefined: these ports and counters do not exist. Allocation behaviour is identical either way.

Test Plan:
- Single flit: input 1 requests output 3 with data 40'hA5_0000_0003 (type 11) -> in_ready=5'b00010 in that cycle; next cycle out_valid[3]=1, out_data slice 3 = 40'hA5_0000_0003; ptr[3]=2.
- Contention: inputs 1, 2 and 4 all send single flits to output 0 for 3 cycles with ptr=0 -> grant order 1, 2, 4; in_ready one-hot each cycle.
- Wormhole lock: input 2 sends head, body, tail to output 1 while input 3 sends a head to output 1 -> input 3 is blocked until the cycle after input 2's tail grant, then granted.
- Backpressure: out_full[1]=1 for 4 cycles mid-packet -> no in_ready and out_valid[1]=0 throughout; lock owner unchanged; after release, the body continues from the same input.
- Masking and reset: PORT_MASK=5'b01111, request to output 4 -> never granted. Reset asserted while output 2 is LOCKED -> out_valid=0, lock IDLE; a new head from another input is granted after reset.
- SA_STATS_EN: 70000 single-flit grants on output 0 -> counter reads 16'hFFFF; stat_clr pulse -> 0 the next cycle.

Source files
------------

// File: rtl/switch_alloc_np.sv
// rtl/switch_alloc_np.sv - NUM_PORTS wormhole switch allocator, per-output RR arbiter and packet lock
// Optional macro SA_STATS_EN adds per-output saturating grant counters.
module switch_alloc_np #(
    parameter int                   NUM_PORTS = 5,
    parameter int                   DATASIZE  = 40,
    parameter logic [NUM_PORTS-1:0] PORT_MASK = 5'b11111
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]  in_label,
    input  logic [NUM_PORTS*DATASIZE-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]            out_full,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [NUM_PORTS-1:0]            out_valid,
    output logic [NUM_PORTS*DATASIZE-1:0]   out_data
`ifdef SA_STATS_EN
    ,
    input  logic                            stat_clr,
    output logic [NUM_PORTS*16-1:0]         stat_grant_cnt
`endif
);

    localparam int N  = NUM_PORTS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} lock_t;

    lock_t                 r_state     [N];
    lock_t                 w_state_nxt [N];
    logic [PW-1:0]         r_ptr       [N];
    logic [PW-1:0]         w_ptr_nxt   [N];
    logic [PW-1:0]         r_owner     [N];
    logic [PW-1:0]         w_owner_nxt [N];
    logic [N-1:0]          w_req       [N];
    logic [N-1:0]          w_low       [N];
    logic [1:0]            w_type      [N];
    logic [N-1:0]          w_gnt_vld;
    logic [PW-1:0]         w_gnt_idx   [N];
    logic [DATASIZE-1:0]   w_gnt_data  [N];
    logic [N-1:0]          w_rdy;
    logic [N-1:0]          r_out_valid;
    logic [N*DATASIZE-1:0] r_out_data;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] k);
        if (int'(k) == N - 1)
            return '0;
        else
            return k + PW'(1);
    endfunction

    // Lowest set bit of the raw label is the route; self-turns (except Local) and absent ports drop it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_low[i]  = in_label[i*N +: N] & (~in_label[i*N +: N] + N'(1));
            w_req[i]  = w_low[i] & PORT_MASK;
            if (i != 0)
                w_req[i][i] = 1'b0;
            if (!PORT_MASK[i])
                w_req[i] = '0;
            w_type[i] = in_data[i*DATASIZE +: 2];
        end
    end

    always_comb begin
        int idx;
        idx = 0;
        for (int j = 0; j < N; j++) begin
            w_state_nxt[j] = r_state[j];
            w_ptr_nxt[j]   = r_ptr[j];
            w_owner_nxt[j] = r_owner[j];
            w_gnt_vld[j]   = 1'b0;
            w_gnt_idx[j]   = '0;
            if (PORT_MASK[j] && !out_full[j]) begin
                if (r_state[j] == S_LOCKED) begin
                    if (w_req[r_owner[j]][j]) begin
                        w_gnt_vld[j] = 1'b1;
                        w_gnt_idx[j] = r_owner[j];
                        if (w_type[r_owner[j]] == 2'b10) begin
                            w_state_nxt[j] = S_IDLE;
                            w_ptr_nxt[j]   = f_next(r_owner[j]);
                        end
                    end
                end else begin
                    // Head (01) and single (11) share bit 0; body/tail may not open an idle output.
                    for (int off = 0; off < N; off++) begin
                        idx = int'(r_ptr[j]) + off;
                        if (idx >= N)
                            idx = idx - N;
                        if (!w_gnt_vld[j] && w_req[idx][j] && w_type[idx][0]) begin
                            w_gnt_vld[j] = 1'b1;
                            w_gnt_idx[j] = PW'(idx);
                        end
                    end
                    if (w_gnt_vld[j]) begin
                        if (w_type[w_gnt_idx[j]] == 2'b11) begin
                            w_ptr_nxt[j] = f_next(w_gnt_idx[j]);
                        end else begin
                            w_state_nxt[j] = S_LOCKED;
                            w_owner_nxt[j] = w_gnt_idx[j];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdy = '0;
        for (int j = 0; j < N; j++) begin
            w_gnt_data[j] = '0;
            for (int i = 0; i < N; i++) begin
                if (int'(w_gnt_idx[j]) == i)
                    w_gnt_data[j] = in_data[i*DATASIZE +: DATASIZE];
            end
            if (w_gnt_vld[j])
                w_rdy[w_gnt_idx[j]] = 1'b1;
        end
        in_ready = rst_n ? w_rdy : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N; j++) begin
                r_state[j] <= S_IDLE;
                r_ptr[j]   <= '0;
                r_owner[j] <= '0;
            end
            r_out_valid <= '0;
            r_out_data  <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                r_state[j]     <= w_state_nxt[j];
                r_ptr[j]       <= w_ptr_nxt[j];
                r_owner[j]     <= w_owner_nxt[j];
                r_out_valid[j] <= w_gnt_vld[j];
                if (w_gnt_vld[j])
                    r_out_data[j*DATASIZE +: DATASIZE] <= w_gnt_data[j];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef SA_STATS_EN
    logic [15:0] r_cnt [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N; j++)
                r_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (stat_clr)
                    r_cnt[j] <= '0;
                else if (w_gnt_vld[j] && r_cnt[j] != 16'hFFFF)
                    r_cnt[j] <= r_cnt[j] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++)
            stat_grant_cnt[j*16 +: 16] = r_cnt[j];
    end
`endif

endmodule

// File: tb/tb_switch_alloc_np.sv
// tb/tb_switch_alloc_np.sv - vector table plus output scoreboard for switch_alloc_np
module tb_switch_alloc_np;

    localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, SNG = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [24:0]  in_label;
    logic [199:0] in_data;
    logic [4:0]   out_full;
    logic [4:0]   in_ready, m_in_ready;
    logic [4:0]   out_valid, m_out_valid;
    logic [199:0] out_data, m_out_data;
`ifdef SA_STATS_EN
    logic         stat_clr;
    logic [79:0]  stat_grant_cnt, m_stat_grant_cnt;
`endif

    always #5 clk = ~clk;

    switch_alloc_np #(.NUM_PORTS(5), .DATASIZE(40), .PORT_MASK(5'b11111)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_label(in_label), .in_data(in_data),
        .out_full(out_full), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data)
`ifdef SA_STATS_EN
        , .stat_clr(stat_clr), .stat_grant_cnt(stat_grant_cnt)
`endif
    );

    switch_alloc_np #(.NUM_PORTS(5), .DATASIZE(40), .PORT_MASK(5'b01111)) u_mask (
        .clk(clk), .rst_n(rst_n), .in_label(in_label), .in_data(in_data),
        .out_full(out_full), .in_ready(m_in_ready), .out_valid(m_out_valid), .out_data(m_out_data)
`ifdef SA_STATS_EN
        , .stat_clr(stat_clr), .stat_grant_cnt(m_stat_grant_cnt)
`endif
    );

    typedef struct {
        string        name;
        logic [24:0]  lbl;
        logic [199:0] dat;
        logic [4:0]   full;
        logic [4:0]   rdy;
        logic         chk_m;
        logic [4:0]   rdy_m;
    } vec_t;

    typedef struct packed {
        logic [4:0]   v;
        logic [199:0] d;
    } exp_t;

    vec_t         tbl[$];
    exp_t         sb[$];
    logic [199:0] m_data;
    int           n_run  = 0;
    int           n_fail = 0;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [24:0] lb(input int i, input int j);
        logic [24:0] r;
        r = '0;
        r[i*5 + j] = 1'b1;
        return r;
    endfunction

    function automatic logic [199:0] fl(input int i, input logic [37:0] p, input logic [1:0] t);
        logic [199:0] r;
        r = '0;
        r[i*40 +: 40] = {p, t};
        return r;
    endfunction

    function automatic vec_t mk(input string nm, input logic [24:0] l, input logic [199:0] d,
                                input logic [4:0] f, input logic [4:0] r);
        vec_t v;
        v.name = nm; v.lbl = l; v.dat = d; v.full = f; v.rdy = r;
        v.chk_m = 1'b0; v.rdy_m = '0;
        return v;
    endfunction

    function automatic int lowbit(input logic [4:0] l);
        for (int k = 0; k < 5; k++)
            if (l[k]) return k;
        return -1;
    endfunction

    // Entered at a negedge; leaves at the following negedge with that cycle's outputs checked.
    task automatic step(input vec_t v);
        exp_t e;
        int   j;
        in_label = v.lbl;
        in_data  = v.dat;
        out_full = v.full;
        #1;
        chk({v.name, "/in_ready"}, in_ready, v.rdy);
        if (v.chk_m)
            chk({v.name, "/mask_in_ready"}, m_in_ready, v.rdy_m);
        e.v = '0;
        for (int i = 0; i < 5; i++) begin
            if (v.rdy[i]) begin
                j = lowbit(v.lbl[i*5 +: 5]);
                if (j >= 0) begin
                    e.v[j] = 1'b1;
                    m_data[j*40 +: 40] = v.dat[i*40 +: 40];
                end
            end
        end
        e.d = m_data;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({v.name, "/scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({v.name, "/out_valid"}, out_valid, e.v);
            chk({v.name, "/out_data"}, out_data, e.d);
        end
        if (v.chk_m)
            chk({v.name, "/mask_out_valid4"}, m_out_valid[4], 1'b0);
    endtask

    initial begin
        vec_t v;
        m_data   = '0;
        rst_n    = 1'b0;
        in_label = lb(1, 3);
        in_data  = fl(1, 38'h1, SNG);
        out_full = '0;
`ifdef SA_STATS_EN
        stat_clr = 1'b0;
`endif
        @(negedge clk);
        chk("reset/in_ready", in_ready, 0);
        chk("reset/out_valid", out_valid, 0);
        chk("reset/out_data", out_data, 0);
        rst_n = 1'b1;

        tbl.push_back(mk("single", lb(1,3), fl(1, 38'h29_4000_0000, 2'b11), 0, 5'b00010));
        tbl.push_back(mk("ptr3", lb(1,3)|lb(2,3), fl(1,38'h11,SNG)|fl(2,38'h12,SNG), 0, 5'b00100));
        tbl.push_back(mk("cont1", lb(1,0)|lb(2,0)|lb(4,0),
                         fl(1,38'h21,SNG)|fl(2,38'h22,SNG)|fl(4,38'h24,SNG), 0, 5'b00010));
        tbl.push_back(mk("cont2", lb(1,0)|lb(2,0)|lb(4,0),
                         fl(1,38'h31,SNG)|fl(2,38'h32,SNG)|fl(4,38'h34,SNG), 0, 5'b00100));
        tbl.push_back(mk("cont3", lb(1,0)|lb(2,0)|lb(4,0),
                         fl(1,38'h41,SNG)|fl(2,38'h42,SNG)|fl(4,38'h44,SNG), 0, 5'b10000));
        tbl.push_back(mk("self", lb(3,3)|lb(0,0), fl(3,38'h53,SNG)|fl(0,38'h50,SNG), 0, 5'b00001));
        tbl.push_back(mk("multihot", lb(1,2)|lb(1,4), fl(1,38'h61,SNG), 0, 5'b00010));
        tbl.push_back(mk("wh_head", lb(2,1)|lb(3,1), fl(2,38'h72,HEAD)|fl(3,38'h73,HEAD), 0, 5'b00100));
        tbl.push_back(mk("wh_body", lb(2,1)|lb(3,1), fl(2,38'h82,BODY)|fl(3,38'h73,HEAD), 0, 5'b00100));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk("bp_hold", lb(2,1)|lb(3,1), fl(2,38'h92,BODY)|fl(3,38'h73,HEAD),
                             5'b00010, 5'b00000));
        tbl.push_back(mk("bp_resume", lb(2,1)|lb(3,1), fl(2,38'h93,BODY)|fl(3,38'h73,HEAD), 0, 5'b00100));
        tbl.push_back(mk("wh_tail", lb(2,1)|lb(3,1), fl(2,38'hA2,TAIL)|fl(3,38'h73,HEAD), 0, 5'b00100));
        tbl.push_back(mk("wh_next", lb(3,1), fl(3,38'h73,HEAD), 0, 5'b01000));
        tbl.push_back(mk("wh_next_tail", lb(3,1), fl(3,38'hB3,TAIL), 0, 5'b01000));
        tbl.push_back(mk("proto_err", lb(4,2)|lb(1,3), fl(4,38'hC4,BODY)|fl(1,38'hC1,TAIL), 0, 5'b00000));
        for (int k = 0; k < 3; k++) begin
            v = mk("mask", lb(1,4)|lb(4,0)|lb(2,3),
                   fl(1,38'hD1,SNG)|fl(4,38'hD4,SNG)|fl(2,38'hD2,SNG), 0, 5'b10110);
            v.chk_m = 1'b1;
            v.rdy_m = 5'b00100;
            tbl.push_back(v);
        end

        foreach (tbl[k])
            step(tbl[k]);

        step(mk("rst_head", lb(1,2), fl(1,38'hE1,HEAD), 0, 5'b00010));
        step(mk("rst_body", lb(1,2)|lb(3,2), fl(1,38'hF1,BODY)|fl(3,38'hF3,HEAD), 0, 5'b00010));
        rst_n = 1'b0;
        in_label = lb(3,2);
        in_data  = fl(3,38'hF3,HEAD);
        #1;
        chk("midrst/out_valid", out_valid, 0);
        chk("midrst/out_data", out_data, 0);
        chk("midrst/in_ready", in_ready, 0);
        m_data = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(mk("post_rst_head", lb(3,2), fl(3,38'hF3,HEAD), 0, 5'b01000));
        step(mk("post_rst_lock", lb(3,2)|lb(1,2), fl(3,38'hF4,TAIL)|fl(1,38'hF5,HEAD), 0, 5'b01000));

`ifdef SA_STATS_EN
        in_label = lb(1,0);
        in_data  = fl(1,38'h1,SNG);
        out_full = '0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("stat_sat", stat_grant_cnt[15:0], 16'hFFFF);
        stat_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_clr", stat_grant_cnt[15:0], 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
